// File: rtl/tag_verify_pkg.sv
// Shared definitions for the RSDP tag verifier: geometry, FSM state type
// and the mod-127 ones'-complement helpers used by the datapath.
package rsdp_pkg;

    localparam int COEF_W  = 7;
    localparam int N_COEF  = 34;
    localparam int N_BYTES = 17;
    localparam int B_W     = COEF_W * N_COEF;
    localparam int CNT_W   = 5;

    localparam logic [COEF_W-1:0] MOD_ZERO_N = 7'h7F;
    localparam logic [CNT_W-1:0]  LAST_BYTE  = CNT_W'(N_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Rotating left inside 7 bits multiplies by 2^s modulo 127.
    function automatic logic [COEF_W-1:0] rotl7(input logic [COEF_W-1:0] x,
                                                input logic [2:0] s);
        logic [2*COEF_W-1:0] w;
        w = {x, x} << s;
        return w[2*COEF_W-1:COEF_W];
    endfunction

    function automatic logic [COEF_W-1:0] madd(input logic [COEF_W-1:0] x,
                                               input logic [COEF_W-1:0] y);
        logic [COEF_W:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        if (sum[COEF_W]) begin
            return sum[COEF_W-1:0] + 7'd1;
        end else begin
            return sum[COEF_W-1:0];
        end
    endfunction

    function automatic logic is_mod_zero(input logic [COEF_W-1:0] x);
        return (x == 7'h00) || (x == MOD_ZERO_N);
    endfunction

endpackage

// File: rtl/tag_verify_if.sv
// Handshake and data bundle between a prover-response source and tag_verify.
interface tag_verify_if
    import rsdp_pkg::*;
();
    logic              start;
    logic [B_W-1:0]    b;
    logic [COEF_W-1:0] e;
    logic [COEF_W-1:0] tag;
    logic [7:0]        rsp_byte;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              busy;
    logic              done;
    logic              pass;
    logic              err;

    modport master (
        output start, b, e, tag, rsp_byte, rsp_valid,
        input  rsp_ready, busy, done, pass, err
    );

    modport slave (
        input  start, b, e, tag, rsp_byte, rsp_valid,
        output rsp_ready, busy, done, pass, err
    );
endinterface

// File: rtl/tag_verify_lane.sv
// One response lane: rotates a challenge coefficient by the response exponent
// and negates it (ones'-complement) when the sign bit is set.
module tag_lane
    import rsdp_pkg::*;
(
    input  logic [COEF_W-1:0] i_coef,
    input  logic [2:0]        i_exp,
    input  logic              i_sign,
    output logic [COEF_W-1:0] o_term
);

    logic [2:0]        w_exp;
    logic [COEF_W-1:0] w_rot;

    // Exponent 7 is folded to 0 before rotating; inversion is negation mod 127.
    always_comb begin
        w_exp = 3'd0;
        w_rot = 7'd0;
        if (i_exp == 3'd7) begin
            w_exp = 3'd0;
        end else begin
            w_exp = i_exp;
        end
        w_rot = rotl7(i_coef, w_exp);
        if (i_sign) begin
            o_term = ~w_rot;
        end else begin
            o_term = w_rot;
        end
    end

endmodule

// File: rtl/tag_verify.sv
// Verifier-side tag checker: folds 17 response bytes onto a seed in mod-127
// arithmetic and compares with the expected tag. Option: TAGVER_RANGE_EN.
module tag_verify
    import rsdp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    tag_verify_if.slave bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [B_W-1:0]    r_b;
    logic [COEF_W-1:0] r_acc;
    logic [COEF_W-1:0] r_tag;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rsp_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;

    logic              w_accept;
    logic              w_last;
    logic              w_match;
    logic              w_verdict;
    logic              w_ready_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic [COEF_W-1:0] w_lane0;
    logic [COEF_W-1:0] w_lane1;
    logic [COEF_W-1:0] w_acc_nxt;

    tag_lane u_lane0 (
        .i_coef (r_b[COEF_W-1:0]),
        .i_exp  (bus.rsp_byte[2:0]),
        .i_sign (bus.rsp_byte[3]),
        .o_term (w_lane0)
    );

    tag_lane u_lane1 (
        .i_coef (r_b[2*COEF_W-1:COEF_W]),
        .i_exp  (bus.rsp_byte[6:4]),
        .i_sign (bus.rsp_byte[7]),
        .o_term (w_lane1)
    );

    assign w_accept  = (r_state == ACC) && bus.rsp_valid && r_rsp_ready;
    assign w_last    = (r_cnt == LAST_BYTE);
    assign w_acc_nxt = madd(madd(r_acc, w_lane0), w_lane1);
    // Both encodings of zero (0x00 and 0x7F) are the same residue.
    assign w_match   = (r_acc == r_tag) || (is_mod_zero(r_acc) && is_mod_zero(r_tag));

`ifdef TAGVER_RANGE_EN
    logic r_err;
    logic w_bad_exp;

    assign w_bad_exp = (bus.rsp_byte[2:0] == 3'd7) || (bus.rsp_byte[6:4] == 3'd7);
    assign w_verdict = w_match && !r_err;

    // Sticky malformed-response flag, cleared when a new check starts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((r_state == IDLE) && bus.start) begin
            r_err <= 1'b0;
        end else if (w_accept && w_bad_exp) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign bus.err = r_err;
`else
    assign w_verdict = w_match;
    assign bus.err   = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ACC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACC: begin
                if (w_accept && w_last) begin
                    w_state_nxt = CMP;
                end else begin
                    w_state_nxt = ACC;
                end
            end
            CMP:     w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the flags are registered.
    always_comb begin
        w_ready_nxt = 1'b0;
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b0;
        case (w_state_nxt)
            IDLE:    w_busy_nxt  = 1'b0;
            ACC:     w_ready_nxt = 1'b1;
            CMP:     w_busy_nxt  = 1'b1;
            DONE:    w_done_nxt  = 1'b1;
            default: w_busy_nxt  = 1'b0;
        endcase
    end

    // State and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rsp_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_ready <= w_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Datapath: latch operands, accumulate accepted bytes, register verdict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_b    <= {B_W{1'b0}};
            r_acc  <= 7'd0;
            r_tag  <= 7'd0;
            r_cnt  <= 5'd0;
            r_pass <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_b    <= bus.b;
                        r_acc  <= bus.e;
                        r_tag  <= bus.tag;
                        r_cnt  <= 5'd0;
                        r_pass <= 1'b0;
                    end
                end
                ACC: begin
                    if (w_accept) begin
                        r_acc <= w_acc_nxt;
                        // Rotate right by one coefficient pair.
                        r_b   <= {r_b[2*COEF_W-1:0], r_b[B_W-1:2*COEF_W]};
                        r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
                    end
                end
                CMP:     r_pass <= w_verdict;
                default: r_pass <= r_pass;
            endcase
        end
    end

    assign bus.rsp_ready = r_rsp_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;

endmodule

// File: doc/tag_verify.md
# tag_verify

Verifier-side tag checker for the RSDP authentication datapath. It receives a prover response vector as a byte stream of 17 bytes. Each byte carries a 3-bit exponent and a sign bit for each of two coefficients. The block accumulates the signed, rotated challenge coefficients onto a seed value in mod-127 ones'-complement arithmetic, then compares the result against the expected tag and reports pass or fail.

## Interface
- No parameters. Fixed geometry: 34 coefficients of 7 bits, 17 response bytes, 2 coefficients per byte.
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `rst_n`  in  1  — reset is synchronous and active-low.
- `start`  in  1  — begin a check; sampled only in IDLE.
- `b`  in  238  — challenge vector, latched on `start`. Coefficient i occupies bits [7i+6:7i].
- `e`  in  7  — accumulator seed, latched on `start`.
- `tag`  in  7  — expected tag, latched on `start`.
- `rsp_byte`  in  8  — response byte. Bits [2:0] and [3] are the exponent and sign of the even coefficient. Bits [6:4] and [7] are the exponent and sign of the odd coefficient.
- `rsp_valid`  in  1  — `rsp_byte` is valid.
- `rsp_ready`  out  1  — block accepts a byte this cycle.
- `busy`  out  1  — high in every state except IDLE.
- `done`  out  1  — one-cycle pulse when the verdict is valid.
- `pass`  out  1  — verdict; held until the next `start`.
- `err`  out  1  — malformed response. Constant 0 when `TAGVER_RANGE_EN` is not defined.

## Operation
- States and transitions:
  - IDLE → ACC on `start`: latch `b`, `e`, `tag`; set acc=`e`, cnt=0; clear `pass` and `err`.
  - ACC: `rsp_ready`=1. When `rsp_valid && rsp_ready`, consume one byte.
  - ACC → CMP after byte 16 is accepted (cnt wraps 16→0).
  - CMP → DONE: register the verdict.
  - DONE → IDLE: `done`=1 for this cycle.
- Byte k consumes challenge coefficients 2k and 2k+1. After each accepted byte the challenge register rotates right by 14 bits, so the current pair always sits in bits [13:0].
- Lane term for exponent s and sign g: rotl7(coef, s); if g=1, bitwise invert the rotated value (negation mod 127). Exponent 7 is treated as 0.
- Per-byte update: acc ← madd(madd(acc, lane0), lane1).
- madd(x,y): compute the 8-bit sum x+y. If bit 7 is set, add 1 (end-around carry) and keep 7 bits.
- Verdict: `pass` = (acc == tag) OR (both values ∈ {0x00, 0x7F}). The two representations of zero compare equal.
- `start` outside IDLE is ignored. A `rsp_valid` outside ACC is ignored and no byte is consumed.

## Timing
- Reset values: `rsp_ready`=0, `busy`=0, `done`=0, `pass`=0, `err`=0, state=IDLE, acc=0, cnt=0.
- Minimum latency from `start` to `done` is 19 cycles: 17 accept cycles, then CMP, then DONE.
- Each stall cycle (`rsp_valid`=0 in ACC) adds one cycle. Accumulator and challenge hold during stalls.
- `rsp_ready` is a registered function of state only. It never depends combinationally on `rsp_valid`.
- `rst_n`=0 in any state returns the block to IDLE with reset values on the next edge. Any partial accumulation is discarded.
- `start` in the DONE cycle is ignored. A new check begins on the first IDLE cycle.

## Configuration
- `TAGVER_RANGE_EN` defined:
  - Any accepted byte with an exponent field equal to 7 sets a sticky `err`.
  - The byte is still consumed and its exponent is treated as 0.
  - A set `err` forces `pass`=0 at CMP.
- `TAGVER_RANGE_EN` undefined: `err` is tied to 0 and exponent 7 is silently treated as 0.

## Structure
- Shared package `rsdp_pkg` holds:
  - Constants: `COEF_W`=7, `N_COEF`=34, `N_BYTES`=17, `MOD_ZERO_N`=7'h7F.
  - State enum type: IDLE, ACC, CMP, DONE.
  - Functions `rotl7` and `madd`.
- One sub-module, `tag_lane`: a combinational block that takes a coefficient, an exponent and a sign, and outputs the 7-bit lane term. Instantiate it twice.

## Test plan
- All-zero `b`, `e`=5, 17 bytes of 0x00, `tag`=5 → `done` in cycle 19 after `start`, `pass`=1.
- Coefficient 0 = 0x01, rest 0, `e`=0, byte0=0x01, rest 0x00 → acc=0x02. With `tag`=0x02, `pass`=1; with `tag`=0x03, `pass`=0.
- Negative-zero case:
  - Stimulus: coefficient 0 = 0x05, `e`=0x05, byte0=0x08, rest 0x00, `tag`=0x00.
  - Response: acc=0x7F, `pass`=1.
- Backpressure and ignored start:
  - Stimulus: drop `rsp_valid` for 3 cycles after byte 4; pulse `start` mid-ACC.
  - Response: `done` arrives 3 cycles later than the unstalled run; result is unchanged; the `start` has no effect.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 after byte 9.
  - Response: IDLE next cycle with all outputs 0. A fresh run then gives the correct verdict.
- With `TAGVER_RANGE_EN`: byte3=0x07, all other inputs per the zero test → `err`=1 and `pass`=0. Without the macro, the same stimulus gives `err`=0 and `pass`=1.
